fifo_push_arbiter: RTL and testbench
====================================

FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default `WIDTH, meaning data word width in bits.
REQ-002 SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one FIFO push port (legal range 2..16).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning the reset, which is asynchronous and active-high.
REQ-005 SHALL have port req, input, NREQ, meaning per-requester push request, held until granted.
REQ-006 SHALL have port data_in, input, NREQ*WIDTH, meaning requester i data at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port gnt, output, NREQ, meaning one-hot grant, combinational, same cycle as the FIFO push.
REQ-008 SHALL have port flush, input, 1, meaning a single-cycle request to discard all FIFO contents.
REQ-009 SHALL have port pop, input, 1, meaning consumer pop request.
REQ-010 SHALL have ports full and empty, input, 1 each, meaning the FIFO status flags.
REQ-011 SHALL have ports fifo_push and fifo_pop, output, 1 each, plus fifo_data, output, WIDTH, meaning the FIFO control and write data.
REQ-012 SHALL have port draining, output, 1, meaning the arbiter is in the DRAIN state.

Function
REQ-013 SHALL implement a two-state FSM: ARB and DRAIN.
REQ-014 In ARB with !full, !flush and any req set, SHALL assert exactly one gnt bit: the first set req scanning upward from ptr, modulo NREQ.
REQ-015 SHALL assert fifo_push = |gnt and fifo_data = data_in slice of the granted requester; when no grant, fifo_data SHALL be 0.
REQ-016 On a grant to requester i, ptr SHALL become (i+1) mod NREQ at the next edge; otherwise ptr SHALL hold.
REQ-017 When full=1, gnt SHALL be 0, even if pop=1 in the same cycle.
REQ-018 In ARB, fifo_pop SHALL equal pop & !empty, and a push and a pop in the same cycle SHALL be allowed.
REQ-019 flush=1 in ARB SHALL suppress all grants that cycle and move the FSM to DRAIN; flush SHALL win over simultaneous req.
REQ-020 In DRAIN, gnt SHALL be 0, fifo_pop SHALL equal !empty, consumer pop SHALL be ignored, and flush SHALL be ignored.
REQ-021 DRAIN SHALL return to ARB on the edge where empty=1 is sampled, so flush on an already-empty FIFO costs exactly one bubble cycle.
REQ-022 fifo_push and fifo_pop SHALL never be asserted while full or empty, respectively, is set.

Reset
REQ-023 While rst=1, state SHALL be ARB, ptr SHALL be 0, and any optional counters SHALL be 0.
REQ-024 During reset, outputs SHALL follow the combinational rules from reset state; asserting rst mid-DRAIN SHALL abort the drain immediately.

Configuration
REQ-025 Macro FIFO_ARB_STATS_EN SHALL control optional per-requester grant statistics.
REQ-026 With FIFO_ARB_STATS_EN defined, the block SHALL add output grant_cnt, NREQ*16 bits, holding one 16-bit saturating count per requester that increments on each grant and is cleared by rst.
REQ-027 Without FIFO_ARB_STATS_EN, neither the port nor the counters SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-028 Shared package fifo_arb_pkg SHALL hold the state enum (ARB, DRAIN), the pointer-width constant/function $clog2(NREQ), and the stats counter width (16).
REQ-029 Combinational sub-module rr_pick (inputs: req vector and ptr; output: one-hot grant) SHALL perform the round-robin selection.
REQ-030 Under FORMAL, the block SHALL assert one-hot-or-zero on gnt, REQ-022, and the REQ-020 rule that no grant occurs in DRAIN.

Verification
REQ-031 NREQ=4, req=4'b1111 held, full=0 for 8 cycles from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, ...
REQ-032 req=4'b1010, ptr=2 -> gnt=1000, then 0010, then 1000.
REQ-033 full=1, req=4'b0001, pop=1 -> gnt=0, fifo_pop=1; next cycle full=0 -> gnt=0001, fifo_push=1.
REQ-034 FIFO holding 3 entries, flush with req=4'b0100 -> no grant; DRAIN for 3 fifo_pop cycles; back in ARB on the cycle after empty=1.
REQ-035 flush with empty=1 -> draining=1 for exactly one cycle, fifo_pop=0 throughout.
REQ-036 FIFO_ARB_STATS_EN defined, requester 0 granted 70000 times -> its grant_cnt saturates at 65535; rst asserted mid-DRAIN -> draining=0 and grant_cnt=0 immediately.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO push arbiter
package fifo_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        DRAIN = 1'b1
    } arb_state_t;

    localparam int STATS_W = 16;

    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rtl/fifo_push_arbiter_rr_pick.sv - combinational round-robin one-hot picker
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic found;
    int   idx;

    // First set request found scanning upward from ptr, wrapping at NREQ
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin FIFO push arbiter with flush/drain; optional FIFO_ARB_STATS_EN grant counters
`ifndef WIDTH
`define WIDTH 8
`endif

module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = `WIDTH,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data_in,
    output logic [NREQ-1:0]         gnt,
    input  logic                    flush,
    input  logic                    pop,
    input  logic                    full,
    input  logic                    empty,
    output logic                    fifo_push,
    output logic                    fifo_pop,
    output logic [WIDTH-1:0]        fifo_data,
`ifdef FIFO_ARB_STATS_EN
    output logic [NREQ*STATS_W-1:0] grant_cnt,
`endif
    output logic                    draining
);

    localparam int PW = ptr_width(NREQ);

    arb_state_t      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   next_ptr;
    logic [NREQ-1:0] pick;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick)
    );

    // Grants only in ARB with room in the FIFO; flush takes priority over requests
    always_comb begin
        gnt       = (state == ARB && !full && !flush) ? pick : '0;
        fifo_push = |gnt;
        fifo_pop  = (state == ARB) ? (pop & ~empty) : ~empty;
        draining  = (state == DRAIN);
    end

    // Write-data mux and the pointer that follows the granted requester
    always_comb begin
        fifo_data = '0;
        next_ptr  = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                fifo_data = data_in[i*WIDTH +: WIDTH];
                next_ptr  = PW'((i + 1) % NREQ);
            end
        end
    end

    // FSM: flush enters DRAIN; DRAIN leaves once the FIFO reports empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
            ptr   <= '0;
        end else begin
            ptr <= next_ptr;
            case (state)
                ARB:     if (flush) state <= DRAIN;
                DRAIN:   if (empty) state <= ARB;
                default: state <= ARB;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar g = 0; g < NREQ; g++) begin : g_stats
        logic [STATS_W-1:0] cnt;
        // Saturating per-requester grant counter
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (gnt[g] && cnt != {STATS_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end
        assign grant_cnt[g*STATS_W +: STATS_W] = cnt;
    end
`endif

`ifdef FORMAL
    // Safety properties on the push/pop controls
    always_comb begin
        assert ($onehot0(gnt));
        assert (!(fifo_push && full));
        assert (!(fifo_pop && empty));
        assert (!(state == DRAIN && |gnt));
    end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - randomized self-checking bench for fifo_push_arbiter
module tb_fifo_push_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush, pop, full, empty;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  gnt;
    logic        fifo_push, fifo_pop, draining;
    logic [7:0]  fifo_data;
`ifdef FIFO_ARB_STATS_EN
    logic [63:0] grant_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;
    bit m_drain = 0;

    always #5 clk = ~clk;

    fifo_push_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .gnt(gnt),
        .flush(flush), .pop(pop), .full(full), .empty(empty),
        .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_data(fifo_data),
`ifdef FIFO_ARB_STATS_EN
        .grant_cnt(grant_cnt),
`endif
        .draining(draining)
    );

    // Reference: first requester at or after the rotating pointer, if pushing is allowed
    function automatic logic [3:0] exp_gnt();
        if (rst) return (req == 0) ? 4'b0 : exp_first(0);
        if (m_drain || full || flush || req == 0) return 4'b0;
        return exp_first(m_ptr);
    endfunction

    function automatic logic [3:0] exp_first(input int p);
        for (int k = 0; k < 4; k++)
            if (req[(p + k) % 4]) return 4'b1 << ((p + k) % 4);
        return 4'b0;
    endfunction

    function automatic logic [7:0] exp_data(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return data_in[i*8 +: 8];
        return 8'h00;
    endfunction

    function automatic logic exp_pop();
        return m_drain ? !empty : (pop && !empty);
    endfunction

    // Advance one clock edge and update the reference state
    task automatic tick();
        logic [3:0] g;
        g = exp_gnt();
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_drain = 0;
        end else begin
            for (int i = 0; i < 4; i++) if (g[i]) m_ptr = (i + 1) % 4;
            m_drain = m_drain ? !empty : flush;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        req = 0; flush = 0; pop = 0; full = 0; empty = 1; data_in = $urandom;
    endtask

    task automatic test_reset();
        idle(); rst = 1; req = 4'b1111;
        @(negedge clk); #1;
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_gnt got=%b exp=0001", gnt); end
        total++; if (draining !== 1'b0) begin bad++; $display("FAIL reset_draining got=%b exp=0", draining); end
        total++; if (fifo_data !== data_in[7:0]) begin bad++; $display("FAIL reset_data got=%h exp=%h", fifo_data, data_in[7:0]); end
        tick(); rst = 0; m_ptr = 0; m_drain = 0; idle();
    endtask

    task automatic test_rotation();
        for (int c = 0; c < 8; c++) begin
            idle(); req = 4'b1111; empty = 0; #1;
            total++;
            if (gnt !== (4'b0001 << (c % 4)) || fifo_push !== 1'b1)
                begin bad++; $display("FAIL rotation c=%0d got=%b push=%b exp=%b", c, gnt, fifo_push, 4'b0001 << (c % 4)); end
            tick();
        end
    endtask

    task automatic test_skip();
        logic [3:0] exp_seq [3];
        exp_seq = '{4'b1000, 4'b0010, 4'b1000};
        idle(); req = 4'b0010; #1; tick();
        for (int c = 0; c < 3; c++) begin
            idle(); req = 4'b1010; #1;
            total++; if (gnt !== exp_seq[c]) begin bad++; $display("FAIL skip c=%0d got=%b exp=%b", c, gnt, exp_seq[c]); end
            tick();
        end
    endtask

    task automatic test_full();
        idle(); req = 4'b0001; full = 1; pop = 1; empty = 0; #1;
        total++; if (gnt !== 4'b0 || fifo_push !== 1'b0 || fifo_pop !== 1'b1)
            begin bad++; $display("FAIL full got gnt=%b push=%b pop=%b exp 0000/0/1", gnt, fifo_push, fifo_pop); end
        tick();
        full = 0; pop = 0; #1;
        total++; if (gnt !== 4'b0001 || fifo_push !== 1'b1)
            begin bad++; $display("FAIL full_release got gnt=%b push=%b exp 0001/1", gnt, fifo_push); end
        tick(); idle();
    endtask

    task automatic test_flush_drain();
        int count = 3;
        idle(); req = 4'b0100; flush = 1; empty = 0; #1;
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL flush_gnt got=%b exp=0000", gnt); end
        tick(); flush = 0;
        while (count > 0) begin
            empty = 0; pop = 0; flush = (count == 2); #1;
            total++; if (fifo_pop !== 1'b1 || draining !== 1'b1 || gnt !== 4'b0)
                begin bad++; $display("FAIL drain_pop n=%0d got pop=%b drn=%b gnt=%b exp 1/1/0000", count, fifo_pop, draining, gnt); end
            tick(); count--;
        end
        flush = 0; empty = 1; pop = 1; #1;
        total++; if (fifo_pop !== 1'b0 || draining !== 1'b1)
            begin bad++; $display("FAIL drain_last got pop=%b drn=%b exp 0/1", fifo_pop, draining); end
        tick(); pop = 0; #1;
        total++; if (draining !== 1'b0 || gnt !== 4'b0100)
            begin bad++; $display("FAIL drain_exit got drn=%b gnt=%b exp 0/0100", draining, gnt); end
        tick(); idle();
    endtask

    task automatic test_flush_empty();
        int ones = 0;
        idle(); flush = 1; empty = 1; tick(); flush = 0;
        for (int c = 0; c < 3; c++) begin
            #1; ones += draining;
            total++; if (fifo_pop !== 1'b0) begin bad++; $display("FAIL flush_empty_pop c=%0d got=%b exp=0", c, fifo_pop); end
            tick();
        end
        total++; if (ones != 1) begin bad++; $display("FAIL flush_empty_bubble got=%0d exp=1", ones); end
    endtask

    task automatic test_random();
        logic [3:0] eg;
        for (int c = 0; c < 400; c++) begin
            req = 4'($urandom); data_in = $urandom;
            full = ($urandom_range(0, 3) == 0); empty = ($urandom_range(0, 3) == 0);
            pop = 1'($urandom); flush = ($urandom_range(0, 15) == 0);
            #1; eg = exp_gnt();
            total++;
            if (gnt !== eg || fifo_push !== (eg != 0) || fifo_data !== exp_data(eg) ||
                fifo_pop !== exp_pop() || draining !== m_drain)
                begin bad++; $display("FAIL random c=%0d got gnt=%b d=%h pop=%b drn=%b exp gnt=%b d=%h pop=%b drn=%b",
                    c, gnt, fifo_data, fifo_pop, draining, eg, exp_data(eg), exp_pop(), m_drain); end
            tick();
        end
        idle();
    endtask

    task automatic test_rst_mid_drain();
        idle(); flush = 1; empty = 0; tick(); flush = 0;
        #1;
        total++; if (draining !== 1'b1) begin bad++; $display("FAIL pre_rst_drain got=%b exp=1", draining); end
        #2 rst = 1; #1;
        total++; if (draining !== 1'b0) begin bad++; $display("FAIL rst_mid_drain got=%b exp=0", draining); end
`ifdef FIFO_ARB_STATS_EN
        total++; if (grant_cnt !== 64'd0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", grant_cnt); end
`endif
        tick(); rst = 0; idle(); m_ptr = 0; m_drain = 0;
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        idle(); req = 4'b0001; empty = 0;
        for (int c = 0; c < 70000; c++) @(negedge clk);
        m_ptr = 1; #1;
        total++; if (grant_cnt !== {48'd0, 16'hFFFF}) begin bad++; $display("FAIL stats_sat got=%h exp=ffff", grant_cnt); end
        idle();
    endtask
`endif

    initial begin
        idle(); rst = 1;
        @(negedge clk);
        test_reset();
        test_rotation();
        test_skip();
        test_full();
        test_flush_drain();
        test_flush_empty();
        test_random();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        test_rst_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
